// File: rtl/accel_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 register interface (64-byte map).
// Define ACCEL_RSP_STATUS_EN for a sticky DATA_READY bit in STATUS; otherwise STATUS reads 8'h01.
module accel_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hAD,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  output logic        o_miso,
  input  logic [11:0] i_xdata,
  input  logic [11:0] i_ydata,
  input  logic [11:0] i_zdata,
  input  logic [11:0] i_temp,
  input  logic        i_sample_valid,
  output logic        o_measure,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic        sclk_d, cs_d;
  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  byte_in;
  logic        byte_done;
  logic        rd_flag;
  logic [5:0]  addr;
  logic [5:0]  ld_addr;
  logic        ld_sh;
  logic [7:0]  sh;
  logic [7:0]  rd_data;
  logic [3:0]  rd_idx, wr_idx;
  logic        wr_hit;
  logic [11:0] xs, ys, zs, ts;
  logic [15:0][7:0] wr_regs;  // 0x1F..0x2E
  logic [7:0]  status;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign byte_in   = {shift_in, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  // The address byte is decoded the same edge it completes, so the first
  // read load takes the incoming byte rather than the addr register.
  assign ld_addr = (state == ADDR) ? byte_in[5:0] : addr;
  assign ld_sh   = byte_done && ((state == ADDR && rd_flag) || state == DATA_RD);
  assign rd_idx  = 4'(ld_addr - 6'h1F);
  assign wr_idx  = 4'(addr - 6'h1F);
  assign wr_hit  = (addr >= 6'h1F) && (addr <= 6'h2E);

  always_comb begin
    rd_data = 8'h00;
    case (ld_addr)
      6'h00: rd_data = DEVID;
      6'h01: rd_data = 8'h1D;
      6'h02: rd_data = PARTID;
      6'h03: rd_data = 8'h01;
      6'h08: rd_data = xs[11:4];
      6'h09: rd_data = ys[11:4];
      6'h0A: rd_data = zs[11:4];
      6'h0B: rd_data = status;
      6'h0E: rd_data = xs[7:0];
      6'h0F: rd_data = {{4{xs[11]}}, xs[11:8]};
      6'h10: rd_data = ys[7:0];
      6'h11: rd_data = {{4{ys[11]}}, ys[11:8]};
      6'h12: rd_data = zs[7:0];
      6'h13: rd_data = {{4{zs[11]}}, zs[11:8]};
      6'h14: rd_data = ts[7:0];
      6'h15: rd_data = {{4{ts[11]}}, ts[11:8]};
      default: if (ld_addr >= 6'h1F && ld_addr <= 6'h2E) rd_data = wr_regs[rd_idx];
    endcase
  end

`ifdef ACCEL_RSP_STATUS_EN
  logic data_ready;
  assign status = {7'b0, data_ready};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 data_ready <= 1'b0;
    else if (i_sample_valid && o_measure)      data_ready <= 1'b1;
    else if (ld_sh && ld_addr == 6'h0E)        data_ready <= 1'b0;
  end
`else
  logic unused_sample_valid;
  assign status              = 8'h01;
  assign unused_sample_valid = i_sample_valid;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (cs_fall) state_nxt = CMD;
        CMD:     if (byte_done)
                   state_nxt = (byte_in == 8'h0B || byte_in == 8'h0A) ? ADDR : IGNORE;
        ADDR:    if (byte_done) state_nxt = rd_flag ? DATA_RD : DATA_WR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      rd_flag   <= 1'b0;
      addr      <= '0;
      sh        <= '0;
      o_miso    <= 1'b0;
      o_busy    <= 1'b0;
      o_measure <= 1'b0;
      xs        <= '0;
      ys        <= '0;
      zs        <= '0;
      ts        <= '0;
      wr_regs   <= '0;
    end else begin
      o_measure <= (wr_regs[14][1:0] == 2'b10);  // POWER_CTL at 0x2D
      if (cs_rise) begin
        bit_cnt <= '0;
        o_miso  <= 1'b0;
        o_busy  <= 1'b0;
      end else begin
        if (state == IDLE && cs_fall) begin
          o_busy  <= 1'b1;
          bit_cnt <= '0;
          xs      <= i_xdata;
          ys      <= i_ydata;
          zs      <= i_zdata;
          ts      <= i_temp;
        end
        if (state != IDLE && sclk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= byte_in[6:0];
        end
        if (state == CMD && byte_done) rd_flag <= (byte_in == 8'h0B);
        if (state == ADDR && byte_done) addr <= byte_in[5:0];
        if (ld_sh) begin
          sh   <= rd_data;
          addr <= ld_addr + 6'd1;
        end
        if (state == DATA_WR && byte_done) begin
          if (wr_hit) begin
            if (addr == 6'h1F && byte_in == 8'h52) begin
              for (int i = 1; i < 16; i++) wr_regs[i] <= 8'h00;
            end else begin
              wr_regs[wr_idx] <= byte_in;
            end
          end
          addr <= addr + 6'd1;
        end
        if (state == DATA_RD && sclk_fall) begin
          o_miso <= sh[7];
          sh     <= {sh[6:0], 1'b0};
        end
        if (state == IGNORE) o_miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: acts as a mode-0 SPI master at clk/16.
module tb_accel_spi_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_sclk = 1'b0;
  logic        i_cs_n = 1'b1;
  logic        i_mosi = 1'b0;
  logic        o_miso;
  logic [11:0] i_xdata = '0, i_ydata = '0, i_zdata = '0, i_temp = '0;
  logic        i_sample_valid = 1'b0;
  logic        o_measure, o_busy;

  int n_vec = 0;
  int n_err = 0;

  accel_spi_responder dut (
    .clk(clk), .rstn(rstn), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .i_xdata(i_xdata), .i_ydata(i_ydata), .i_zdata(i_zdata),
    .i_temp(i_temp), .i_sample_valid(i_sample_valid), .o_measure(o_measure),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // One byte, MSB first; MISO sampled just before each rising SCLK edge.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      i_mosi = tx[i];
      #80;
      rx[i] = o_miso;
      i_sclk = 1'b1;
      #80;
      i_sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    i_cs_n = 1'b0;
    #160;
  endtask

  task automatic cs_stop();
    #160;
    i_cs_n = 1'b1;
    #200;
  endtask

  task automatic wr1(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] r;
    cs_start();
    xfer(8'h0A, r);
    xfer({2'b00, a}, r);
    xfer(d, r);
    cs_stop();
  endtask

  task automatic rd1(input logic [5:0] a, output logic [7:0] d);
    logic [7:0] r;
    cs_start();
    xfer(8'h0B, r);
    xfer({2'b00, a}, r);
    xfer(8'h00, d);
    cs_stop();
  endtask

  task automatic test_reset();
    n_vec++; if (o_miso !== 1'b0)    begin n_err++; $display("FAIL reset_miso got %b exp 0", o_miso); end
    n_vec++; if (o_busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    n_vec++; if (o_measure !== 1'b0) begin n_err++; $display("FAIL reset_measure got %b exp 0", o_measure); end
  endtask

  task automatic test_read_id();
    logic [7:0] r;
    logic [7:0] exp_id [4] = '{8'hAD, 8'h1D, 8'hF2, 8'h01};
    cs_start();
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL busy_open got %b exp 1", o_busy); end
    xfer(8'h0B, r);
    xfer(8'h00, r);
    for (int i = 0; i < 4; i++) begin
      xfer(8'h00, r);
      n_vec++; if (r !== exp_id[i]) begin n_err++; $display("FAIL read_id[%0d] got %h exp %h", i, r, exp_id[i]); end
    end
    cs_stop();
  endtask

  task automatic test_write_read();
    logic [7:0] r;
    wr1(6'h2D, 8'h02);
    n_vec++; if (o_measure !== 1'b1) begin n_err++; $display("FAIL measure_on got %b exp 1", o_measure); end
    rd1(6'h2D, r);
    n_vec++; if (r !== 8'h02) begin n_err++; $display("FAIL power_ctl got %h exp 02", r); end
    rd1(6'h0B, r);
`ifdef ACCEL_RSP_STATUS_EN
    n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL status got %h exp 00", r); end
`else
    n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL status got %h exp 01", r); end
`endif
  endtask

  task automatic test_snapshot();
    logic [7:0] r;
    logic [7:0] exp_b [6] = '{8'hA5, 8'h07, 8'hF0, 8'h00, 8'h00, 8'hF8};
    i_xdata = 12'hF85;
    i_ydata = 12'h7A5;
    i_zdata = 12'h0F0;
    i_temp  = 12'h800;
    cs_start();
    xfer(8'h0B, r);
    xfer(8'h0E, r);
    i_xdata = 12'h123;
    xfer(8'h00, r);
    n_vec++; if (r !== 8'h85) begin n_err++; $display("FAIL snap_xl got %h exp 85", r); end
    xfer(8'h00, r);
    n_vec++; if (r !== 8'hFF) begin n_err++; $display("FAIL snap_xh got %h exp ff", r); end
    for (int i = 0; i < 6; i++) begin
      xfer(8'h00, r);
      n_vec++; if (r !== exp_b[i]) begin n_err++; $display("FAIL snap_yzt[%0d] got %h exp %h", i, r, exp_b[i]); end
    end
    cs_stop();
    rd1(6'h0E, r);
    n_vec++; if (r !== 8'h23) begin n_err++; $display("FAIL new_xl got %h exp 23", r); end
    rd1(6'h0F, r);
    n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL new_xh got %h exp 01", r); end
  endtask

  task automatic test_wrap();
    logic [7:0] r;
    logic [7:0] exp_w [3] = '{8'h00, 8'h00, 8'hAD};
    cs_start();
    xfer(8'h0A, r);
    xfer(8'h3F, r);
    xfer(8'h11, r);
    xfer(8'h22, r);
    cs_stop();
    cs_start();
    xfer(8'h0B, r);
    xfer(8'h3E, r);
    for (int i = 0; i < 3; i++) begin
      xfer(8'h00, r);
      n_vec++; if (r !== exp_w[i]) begin n_err++; $display("FAIL wrap[%0d] got %h exp %h", i, r, exp_w[i]); end
    end
    cs_stop();
  endtask

  task automatic test_cs_abort();
    logic [7:0] r;
    wr1(6'h20, 8'h3C);
    cs_start();
    xfer(8'h0A, r);
    xfer(8'h20, r);
    for (int i = 0; i < 5; i++) begin
      i_mosi = 1'b1;
      #80 i_sclk = 1'b1;
      #80 i_sclk = 1'b0;
    end
    cs_stop();
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", o_busy); end
    rd1(6'h20, r);
    n_vec++; if (r !== 8'h3C) begin n_err++; $display("FAIL abort_reg got %h exp 3c", r); end
  endtask

  task automatic test_soft_reset();
    logic [7:0] r;
    wr1(6'h20, 8'h55);
    rd1(6'h20, r);
    n_vec++; if (r !== 8'h55) begin n_err++; $display("FAIL pre_soft got %h exp 55", r); end
    wr1(6'h1F, 8'h52);
    rd1(6'h20, r);
    n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL soft_20 got %h exp 00", r); end
    rd1(6'h1F, r);
    n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL soft_1f got %h exp 00", r); end
    n_vec++; if (o_measure !== 1'b0) begin n_err++; $display("FAIL soft_measure got %b exp 0", o_measure); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] r;
    cs_start();
    xfer(8'h33, r);
    n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL badcmd_cmd got %h exp 00", r); end
    for (int i = 0; i < 3; i++) begin
      xfer(8'hFF, r);
      n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL badcmd[%0d] got %h exp 00", i, r); end
    end
    cs_stop();
    rd1(6'h00, r);
    n_vec++; if (r !== 8'hAD) begin n_err++; $display("FAIL after_bad got %h exp ad", r); end
  endtask

  initial begin
    #23 rstn = 1'b1;
    @(negedge clk);
    #40;
    test_reset();
    test_read_id();
    test_write_read();
    test_snapshot();
    test_wrap();
    test_cs_abort();
    test_soft_reset();
    test_bad_cmd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
